// File: rtl/alu_accumulator_datapath.sv
// rtl/alu_accumulator_datapath.sv - 8-bit accumulator/operand datapath with combinational ALU and tri-state bus drive
//
// Purpose: holds accumulator A and operand B, both loaded from the shared data
// bus, and computes an ALU result plus {sign, zero, parity, carry} flags.
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset (clears A, B)
//   data_bus          shared tri-state bus, driven only while an OE is active
//   WE_A / WE_B       load A / B from data_bus at the rising edge
//   OE_ALU/OE_A/OE_B  bus drive enables, priority OE_ALU > OE_A > OE_B
//   alu_opcode        ALU operation select (0x10-0x1F behave as CLR)
//   a_out / b_out     current register values
//   alu_out / status  combinational ALU result and flags

module alu_accumulator_datapath #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    inout  wire  [DATA_WIDTH-1:0] data_bus,
    input  logic                  WE_A,
    input  logic                  OE_A,
    input  logic                  WE_B,
    input  logic                  OE_B,
    input  logic                  OE_ALU,
    input  logic [4:0]            alu_opcode,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic [DATA_WIDTH-1:0] alu_out,
    output logic [3:0]            status
);

    localparam logic [4:0] OP_ADD   = 5'h00;
    localparam logic [4:0] OP_SUB   = 5'h01;
    localparam logic [4:0] OP_INC   = 5'h02;
    localparam logic [4:0] OP_DEC   = 5'h03;
    localparam logic [4:0] OP_AND   = 5'h04;
    localparam logic [4:0] OP_OR    = 5'h05;
    localparam logic [4:0] OP_XOR   = 5'h06;
    localparam logic [4:0] OP_NOT   = 5'h07;
    localparam logic [4:0] OP_SHL   = 5'h08;
    localparam logic [4:0] OP_SHR   = 5'h09;
    localparam logic [4:0] OP_ROL   = 5'h0A;
    localparam logic [4:0] OP_ROR   = 5'h0B;
    localparam logic [4:0] OP_PASSA = 5'h0C;
    localparam logic [4:0] OP_PASSB = 5'h0D;
    localparam logic [4:0] OP_NEG   = 5'h0E;

    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;

    logic [DATA_WIDTH-1:0] add_x, add_y, add_y_eff;
    logic                  add_sub;
    logic [DATA_WIDTH:0]   add_sum;
    logic                  add_cy;

    logic [DATA_WIDTH-1:0] alu_c;
    logic                  alu_cy;

    logic                  bus_en;
    logic [DATA_WIDTH-1:0] bus_val;

    // A register driving the bus while loading would just read itself back,
    // so WE together with its own OE is a hold.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (WE_A && !OE_A) a_d = data_bus;
        if (WE_B && !OE_B) b_d = data_bus;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    // Operand selection for the single shared adder/subtractor.
    always_comb begin
        add_x   = a_q;
        add_y   = b_q;
        add_sub = 1'b0;
        case (alu_opcode)
            OP_SUB: add_sub = 1'b1;
            OP_INC: add_y   = ONE;
            OP_DEC: begin
                add_y   = ONE;
                add_sub = 1'b1;
            end
            OP_NEG: begin
                add_x   = '0;
                add_y   = a_q;
                add_sub = 1'b1;
            end
            default: ;
        endcase
    end

    // Subtraction is x + ~y + 1; the top bit is then a "no borrow" flag,
    // so it is inverted to report borrow.
    assign add_y_eff = add_sub ? ~add_y : add_y;
    assign add_sum   = {1'b0, add_x} + {1'b0, add_y_eff} + {{DATA_WIDTH{1'b0}}, add_sub};
    assign add_cy    = add_sum[DATA_WIDTH] ^ add_sub;

    always_comb begin
        alu_c  = '0;
        alu_cy = 1'b0;
        case (alu_opcode)
            OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_NEG: begin
                alu_c  = add_sum[DATA_WIDTH-1:0];
                alu_cy = add_cy;
            end
            OP_AND:   alu_c = a_q & b_q;
            OP_OR:    alu_c = a_q | b_q;
            OP_XOR:   alu_c = a_q ^ b_q;
            OP_NOT:   alu_c = ~a_q;
            OP_SHL: begin
                alu_c  = {a_q[DATA_WIDTH-2:0], 1'b0};
                alu_cy = a_q[DATA_WIDTH-1];
            end
            OP_SHR: begin
                alu_c  = {1'b0, a_q[DATA_WIDTH-1:1]};
                alu_cy = a_q[0];
            end
            OP_ROL: begin
                alu_c  = {a_q[DATA_WIDTH-2:0], a_q[DATA_WIDTH-1]};
                alu_cy = a_q[DATA_WIDTH-1];
            end
            OP_ROR: begin
                alu_c  = {a_q[0], a_q[DATA_WIDTH-1:1]};
                alu_cy = a_q[0];
            end
            OP_PASSA: alu_c = a_q;
            OP_PASSB: alu_c = b_q;
            default:  ;  // CLR and reserved codes
        endcase
    end

    assign status = {alu_c[DATA_WIDTH-1], ~|alu_c, ^alu_c, alu_cy};

    // Only one source ever drives, so the block never contends with itself.
    always_comb begin
        bus_en  = 1'b1;
        bus_val = '0;
        if (OE_ALU)    bus_val = alu_c;
        else if (OE_A) bus_val = a_q;
        else if (OE_B) bus_val = b_q;
        else           bus_en  = 1'b0;
    end

    assign data_bus = bus_en ? bus_val : {DATA_WIDTH{1'bz}};

    assign a_out   = a_q;
    assign b_out   = b_q;
    assign alu_out = alu_c;

endmodule

// File: tb/tb_alu_accumulator_datapath.sv
// tb/tb_alu_accumulator_datapath.sv - self-checking bench for alu_accumulator_datapath

module tb_alu_accumulator_datapath;

    logic       clk;
    logic       reset;
    logic       WE_A, OE_A, WE_B, OE_B, OE_ALU;
    logic [4:0] alu_opcode;
    logic [7:0] a_out, b_out, alu_out;
    logic [3:0] status;
    wire  [7:0] data_bus;
    logic       tb_oe;
    logic [7:0] tb_data;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_a, exp_b;

    assign data_bus = tb_oe ? tb_data : 8'hzz;

    alu_accumulator_datapath #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_bus   (data_bus),
        .WE_A       (WE_A),
        .OE_A       (OE_A),
        .WE_B       (WE_B),
        .OE_B       (OE_B),
        .OE_ALU     (OE_ALU),
        .alu_opcode (alu_opcode),
        .a_out      (a_out),
        .b_out      (b_out),
        .alu_out    (alu_out),
        .status     (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: returns {status, C} from plain integer arithmetic.
    function automatic logic [11:0] model(input int op, input int a, input int b);
        int c;
        int cy;
        int ones;
        c  = 0;
        cy = 0;
        case (op)
            0:  begin c = a + b;   cy = (a + b > 255); end
            1:  begin c = a - b;   cy = (a < b);       end
            2:  begin c = a + 1;   cy = (a == 255);    end
            3:  begin c = a - 1;   cy = (a == 0);      end
            4:  c = a & b;
            5:  c = a | b;
            6:  c = a ^ b;
            7:  c = 255 - a;
            8:  begin c = a * 2;                 cy = (a >= 128); end
            9:  begin c = a / 2;                 cy = a % 2;      end
            10: begin c = a * 2 + a / 128;       cy = (a >= 128); end
            11: begin c = a / 2 + (a % 2) * 128; cy = a % 2;      end
            12: c = a;
            13: c = b;
            14: begin c = 256 - a; cy = (a != 0); end
            default: c = 0;
        endcase
        c = c % 256;
        if (c < 0) c = c + 256;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += (c >> i) & 1;
        model = {(c >= 128) ? 1'b1 : 1'b0, (c == 0) ? 1'b1 : 1'b0,
                 ones[0], (cy != 0) ? 1'b1 : 1'b0, c[7:0]};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_a(input logic [7:0] v);
        tb_oe = 1'b1; tb_data = v; WE_A = 1'b1;
        @(posedge clk); #1;
        WE_A = 1'b0; tb_oe = 1'b0;
        exp_a = v;
    endtask

    task automatic load_b(input logic [7:0] v);
        tb_oe = 1'b1; tb_data = v; WE_B = 1'b1;
        @(posedge clk); #1;
        WE_B = 1'b0; tb_oe = 1'b0;
        exp_b = v;
    endtask

    task automatic check_alu(input string tag, input int op);
        logic [11:0] m;
        alu_opcode = op[4:0];
        #1;
        m = model(op, exp_a, exp_b);
        check({tag, "_c"},      {8'h0, alu_out}, {8'h0, m[7:0]});
        check({tag, "_status"}, {12'h0, status}, {12'h0, m[11:8]});
    endtask

    initial begin
        logic [11:0] m;
        int op;
        reset = 1'b1; WE_A = 0; OE_A = 0; WE_B = 0; OE_B = 0; OE_ALU = 0;
        alu_opcode = 5'h00; tb_oe = 0; tb_data = 8'h00;
        exp_a = 0; exp_b = 0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #1;

        check("reset_a",      {8'h0, a_out},  16'h0000);
        check("reset_b",      {8'h0, b_out},  16'h0000);
        check("reset_c",      {8'h0, alu_out}, 16'h0000);
        check("reset_status", {12'h0, status}, 16'h0004);

        // Asynchronous reset mid-cycle, no clock edge needed.
        load_a(8'h5A);
        check("load_5a", {8'h0, a_out}, 16'h005A);
        #2 reset = 1'b1;
        #1;
        check("async_reset_a",      {8'h0, a_out},  16'h0000);
        check("async_reset_status", {12'h0, status}, 16'h0004);
        exp_a = 0; exp_b = 0;
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("post_reset_hold", {8'h0, a_out}, 16'h0000);

        // Load latency and bus drive.
        tb_oe = 1'b1; tb_data = 8'h3C; WE_A = 1'b1;
        #1;
        check("before_edge", {8'h0, a_out}, 16'h0000);
        @(posedge clk); #1;
        WE_A = 1'b0; tb_oe = 1'b0; exp_a = 8'h3C;
        check("load_3c", {8'h0, a_out}, 16'h003C);
        OE_A = 1'b1; #1;
        check("bus_oe_a", {8'h0, data_bus}, 16'h003C);
        OE_A = 1'b0;
        // With no OE the block must not drive: the bench's own value passes untouched.
        tb_oe = 1'b1; tb_data = 8'h00; #1;
        check("bus_released", {8'h0, data_bus}, 16'h0000);
        tb_oe = 1'b0;

        // Directed arithmetic and logic vectors.
        load_a(8'hFF); load_b(8'h01);
        check_alu("add_ff_01", 0);
        check("add_ff_01_lit", {4'h0, status, alu_out}, 16'h0500);
        load_a(8'h05); load_b(8'h07);
        check_alu("sub_05_07", 1);
        check("sub_05_07_c", {8'h0, alu_out}, 16'h00FE);
        load_a(8'h80);
        check_alu("neg_80", 14);
        check("neg_80_lit", {7'h0, status[0], alu_out}, 16'h0180);
        load_a(8'h81);
        check_alu("shl_81", 8);
        check("shl_81_lit", {7'h0, status[0], alu_out}, 16'h0102);
        check_alu("ror_81", 11);
        check("ror_81_lit", {7'h0, status[0], alu_out}, 16'h01C0);
        load_a(8'hF0); load_b(8'h0F);
        check_alu("xor_f0_0f", 6);
        check("xor_lit", {4'h0, status, alu_out}, 16'h08FF);
        load_a(8'h00);
        check_alu("dec_00", 3);
        check_alu("neg_00", 14);

        // Bus priority.
        load_a(8'h12); load_b(8'h34);
        alu_opcode = 5'h01; OE_ALU = 1; OE_A = 1; OE_B = 1; #1;
        m = model(1, exp_a, exp_b);
        check("prio_all", {8'h0, data_bus}, {8'h0, m[7:0]});
        OE_ALU = 0; #1;
        check("prio_a_b", {8'h0, data_bus}, 16'h0012);
        OE_A = 0; #1;
        check("prio_b", {8'h0, data_bus}, 16'h0034);
        OE_B = 0;

        // Reserved opcode.
        check_alu("rsvd_15", 5'h15);
        check("rsvd_15_lit", {4'h0, status, alu_out}, 16'h0400);

        // Accumulate: A <= A + B each clock.
        load_a(8'h10); load_b(8'h01);
        alu_opcode = 5'h00; OE_ALU = 1; WE_A = 1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            exp_a = (exp_a + exp_b) % 256;
            check($sformatf("accum_%0d", i), {8'h0, a_out}, exp_a[15:0]);
        end
        OE_ALU = 0; WE_A = 0;

        // Randomized operands and opcodes against the reference model.
        for (int k = 0; k < 60; k++) begin
            load_a($urandom_range(0, 255));
            load_b($urandom_range(0, 255));
            op = $urandom_range(0, 31);
            check_alu($sformatf("rand%0d_op%02h", k, op), op);
            OE_ALU = 1; #1;
            m = model(op, exp_a, exp_b);
            check($sformatf("rand%0d_bus", k), {8'h0, data_bus}, {8'h0, m[7:0]});
            OE_ALU = 0;
            check($sformatf("rand%0d_b", k), {8'h0, b_out}, exp_b[15:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
